unisim_sram_b_1w1r_param: RTL and testbench

- Parametrised 1-write/1-read SRAM wrapper built from BRAM_2048x8 primitives.
- Successor of the fixed-geometry generated wrappers: arbitrary address and data width, with vertical banking (depth) and horizontal slicing (width).
- Adds three behaviours the generated wrappers lack: write-to-read forwarding on same-address collision, an optional output register stage, and output hold when no read is issued.
- Used by accelerator PLM (private local memory) instances in the unisim techmap.

---
 rtl/unisim_sram_pkg.sv | 15 +
 rtl/BRAM_2048x8.sv | 29 ++
 rtl/unisim_sram_b_1w1r_fwd.sv | 46 ++++
 rtl/unisim_sram_b_1w1r_param.sv | 125 ++++++++++++
 tb/tb_unisim_sram_b_1w1r_param.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/unisim_sram_pkg.sv
// Shared geometry constants and helpers for the BRAM_2048x8-based SRAM wrappers.
package unisim_sram_pkg;

    localparam int unsigned BRAM_ABITS = 11;
    localparam int unsigned BRAM_DBITS = 8;

    function automatic int unsigned nbanks_v(input int unsigned abits);
        return 1 << (abits - BRAM_ABITS);
    endfunction

    function automatic int unsigned nslices_h(input int unsigned dbits);
        return (dbits + BRAM_DBITS - 1) / BRAM_DBITS;
    endfunction

endpackage

// File: rtl/BRAM_2048x8.sv
// Behavioural 2048x8 block RAM primitive: two synchronous ports, bit-masked writes, read-first.
module BRAM_2048x8 (
    input  logic        CLK,
    input  logic        CE0,
    input  logic [10:0] A0,
    input  logic [7:0]  D0,
    input  logic        WE0,
    input  logic [7:0]  WEM0,
    input  logic        CE1,
    input  logic [10:0] A1,
    input  logic [7:0]  D1,
    input  logic        WE1,
    input  logic [7:0]  WEM1,
    output logic [7:0]  Q1
);

    logic [7:0] mem [2048];

    always_ff @(posedge CLK) begin
        if (CE0 && WE0)
            mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1) begin
            if (WE1)
                mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
            Q1 <= mem[A1];
        end
    end

endmodule

// File: rtl/unisim_sram_b_1w1r_fwd.sv
// Same-address write/read collision detect and write-first merge of the captured write data.
module unisim_sram_b_1w1r_fwd #(
    parameter int ABITS  = 12,
    parameter int DBITS  = 16,
    parameter int FWD_EN = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE0,
    input  logic             WE0,
    input  logic             CE1,
    input  logic [ABITS-1:0] A0,
    input  logic [ABITS-1:0] A1,
    input  logic [DBITS-1:0] D0,
    input  logic [DBITS-1:0] WEM0,
    input  logic [DBITS-1:0] bank_q,
    output logic [DBITS-1:0] rdata,
    output logic             hit
);

    logic             hit_d;
    logic             hit_q;
    logic [DBITS-1:0] d_q;
    logic [DBITS-1:0] wem_q;

    // With FWD_EN=0 hit_d is constant 0, so the capture registers collapse away.
    assign hit_d = (FWD_EN != 0) && CE0 && WE0 && CE1 && (A0 == A1);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hit_q <= 1'b0;
            d_q   <= '0;
            wem_q <= '0;
        end else begin
            hit_q <= hit_d;
            if (hit_d) begin
                d_q   <= D0;
                wem_q <= WEM0;
            end
        end
    end

    assign rdata = hit_q ? ((d_q & wem_q) | (bank_q & ~wem_q)) : bank_q;
    assign hit   = hit_q;

endmodule

// File: rtl/unisim_sram_b_1w1r_param.sv
// Parametrised 1W/1R SRAM on BRAM_2048x8 tiles: depth banking, width slicing, forwarding, read hold.
module unisim_sram_b_1w1r_param
    import unisim_sram_pkg::*;
#(
    parameter int ABITS   = 12,
    parameter int DBITS   = 16,
    parameter int OUT_REG = 0,
    parameter int FWD_EN  = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE0,
    input  logic [ABITS-1:0] A0,
    input  logic [DBITS-1:0] D0,
    input  logic             WE0,
    input  logic [DBITS-1:0] WEM0,
    input  logic             CE1,
    input  logic [ABITS-1:0] A1,
    output logic [DBITS-1:0] Q1,
    output logic             COLL
);

    localparam int NV = int'(nbanks_v(ABITS));
    localparam int NH = int'(nslices_h(DBITS));
    localparam int VB = (ABITS > int'(BRAM_ABITS)) ? ABITS - int'(BRAM_ABITS) : 1;
    localparam int PW = NH * int'(BRAM_DBITS);

    logic [VB-1:0]             wbank, rbank, selv_q;
    logic [NV-1:0]             wce, rce;
    logic [PW-1:0]             dpad, mpad;
    logic [NV-1:0][PW-1:0]     bank_q;
    logic [DBITS-1:0]          mux_q, fwd_q, rd_data, hold_q;
    logic                      rd_q, hit;

    assign wbank = VB'(A0 >> BRAM_ABITS);
    assign rbank = VB'(A1 >> BRAM_ABITS);

    always_comb begin
        dpad = '0;
        mpad = '0;
        dpad[DBITS-1:0] = D0;
        mpad[DBITS-1:0] = WEM0;
        for (int unsigned v = 0; v < NV; v++) begin
            wce[v] = CE0 && (wbank == VB'(v));
            rce[v] = CE1 && (rbank == VB'(v));
        end
    end

    for (genvar v = 0; v < NV; v++) begin : g_bank
        for (genvar h = 0; h < NH; h++) begin : g_slice
            BRAM_2048x8 u_bram (
                .CLK  (CLK),
                .CE0  (wce[v]),
                .A0   (A0[BRAM_ABITS-1:0]),
                .D0   (dpad[8*h +: 8]),
                .WE0  (WE0),
                .WEM0 (mpad[8*h +: 8]),
                .CE1  (rce[v]),
                .A1   (A1[BRAM_ABITS-1:0]),
                .D1   (8'h00),
                .WE1  (1'b0),
                .WEM1 (8'h00),
                .Q1   (bank_q[v][8*h +: 8])
            );
        end
    end

    assign mux_q = bank_q[selv_q][DBITS-1:0];

    unisim_sram_b_1w1r_fwd #(
        .ABITS  (ABITS),
        .DBITS  (DBITS),
        .FWD_EN (FWD_EN)
    ) u_fwd (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .CE0    (CE0),
        .WE0    (WE0),
        .CE1    (CE1),
        .A0     (A0),
        .A1     (A1),
        .D0     (D0),
        .WEM0   (WEM0),
        .bank_q (mux_q),
        .rdata  (fwd_q),
        .hit    (hit)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            selv_q <= '0;
            rd_q   <= 1'b0;
            hold_q <= '0;
        end else begin
            rd_q <= CE1;
            if (CE1)
                selv_q <= rbank;
            if (rd_q)
                hold_q <= fwd_q;
        end
    end

    // Primitive output is only trusted in the cycle right after a read; otherwise replay hold_q.
    assign rd_data = rd_q ? fwd_q : hold_q;

    if (OUT_REG != 0) begin : g_outreg
        logic [DBITS-1:0] out_q;
        logic             coll_q;
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                out_q  <= '0;
                coll_q <= 1'b0;
            end else begin
                out_q  <= rd_data;
                coll_q <= hit;
            end
        end
        assign Q1   = out_q;
        assign COLL = coll_q;
    end else begin : g_noreg
        assign Q1   = rd_data;
        assign COLL = hit;
    end

endmodule

// File: tb/tb_unisim_sram_b_1w1r_param.sv
// Directed bench: DUT a (ABITS=12, DBITS=16, OUT_REG=0) and DUT b (ABITS=12, DBITS=12, OUT_REG=1).
module tb_unisim_sram_b_1w1r_param;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;

    logic        a_ce0, a_we0, a_ce1, a_coll;
    logic [11:0] a_a0, a_a1;
    logic [15:0] a_d0, a_wem0, a_q1;

    logic        b_ce0, b_we0, b_ce1, b_coll;
    logic [11:0] b_a0, b_a1;
    logic [11:0] b_d0, b_wem0, b_q1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    unisim_sram_b_1w1r_param #(.ABITS(12), .DBITS(16), .OUT_REG(0), .FWD_EN(1)) u_a (
        .CLK(CLK), .RSTN(RSTN), .CE0(a_ce0), .A0(a_a0), .D0(a_d0), .WE0(a_we0),
        .WEM0(a_wem0), .CE1(a_ce1), .A1(a_a1), .Q1(a_q1), .COLL(a_coll)
    );

    unisim_sram_b_1w1r_param #(.ABITS(12), .DBITS(12), .OUT_REG(1), .FWD_EN(1)) u_b (
        .CLK(CLK), .RSTN(RSTN), .CE0(b_ce0), .A0(b_a0), .D0(b_d0), .WE0(b_we0),
        .WEM0(b_wem0), .CE1(b_ce1), .A1(b_a1), .Q1(b_q1), .COLL(b_coll)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        a_ce0 = 0; a_we0 = 0; a_ce1 = 0; a_a0 = '0; a_a1 = '0; a_d0 = '0; a_wem0 = '0;
        b_ce0 = 0; b_we0 = 0; b_ce1 = 0; b_a0 = '0; b_a1 = '0; b_d0 = '0; b_wem0 = '0;
    endtask

    task automatic a_write(input logic [11:0] addr, input logic [15:0] data, input logic [15:0] mask);
        a_ce0 = 1; a_we0 = 1; a_a0 = addr; a_d0 = data; a_wem0 = mask;
        tick();
        a_ce0 = 0; a_we0 = 0;
    endtask

    task automatic test_reset();
        idle_all();
        RSTN = 0;
        tick();
        tick();
        total_cnt++; if (a_q1 !== 16'h0) $display("FAIL reset_a_q1 got %h want 0000", a_q1); else pass_cnt++;
        total_cnt++; if (a_coll !== 1'b0) $display("FAIL reset_a_coll got %b want 0", a_coll); else pass_cnt++;
        total_cnt++; if (b_q1 !== 12'h0) $display("FAIL reset_b_q1 got %h want 000", b_q1); else pass_cnt++;
        total_cnt++; if (b_coll !== 1'b0) $display("FAIL reset_b_coll got %b want 0", b_coll); else pass_cnt++;
        RSTN = 1;
        tick();
    endtask

    task automatic test_banks();
        a_write(12'h000, 16'hBEEF, 16'hFFFF);
        a_write(12'h800, 16'hCAFE, 16'hFFFF);
        a_ce1 = 1; a_a1 = 12'h800;
        tick();
        total_cnt++; if (a_q1 !== 16'hCAFE) $display("FAIL bank1_read got %h want CAFE", a_q1); else pass_cnt++;
        total_cnt++; if (a_coll !== 1'b0) $display("FAIL bank1_coll got %b want 0", a_coll); else pass_cnt++;
        a_a1 = 12'h000;
        tick();
        total_cnt++; if (a_q1 !== 16'hBEEF) $display("FAIL bank0_b2b_read got %h want BEEF", a_q1); else pass_cnt++;
        a_ce1 = 0;
    endtask

    task automatic test_mask();
        a_write(12'h005, 16'h1234, 16'hFFFF);
        a_write(12'h005, 16'hFFFF, 16'h00F0);
        a_ce1 = 1; a_a1 = 12'h005;
        tick();
        a_ce1 = 0;
        total_cnt++; if (a_q1 !== 16'h12F4) $display("FAIL mask_read got %h want 12F4", a_q1); else pass_cnt++;
    endtask

    task automatic test_collision();
        a_write(12'h010, 16'hAAAA, 16'hFFFF);
        a_ce0 = 1; a_we0 = 1; a_a0 = 12'h010; a_d0 = 16'h5555; a_wem0 = 16'hFF00;
        a_ce1 = 1; a_a1 = 12'h010;
        tick();
        a_ce0 = 0; a_we0 = 0;
        total_cnt++; if (a_q1 !== 16'h55AA) $display("FAIL coll_fwd_data got %h want 55AA", a_q1); else pass_cnt++;
        total_cnt++; if (a_coll !== 1'b1) $display("FAIL coll_flag got %b want 1", a_coll); else pass_cnt++;
        tick();
        a_ce1 = 0;
        total_cnt++; if (a_q1 !== 16'h55AA) $display("FAIL coll_reread got %h want 55AA", a_q1); else pass_cnt++;
        total_cnt++; if (a_coll !== 1'b0) $display("FAIL coll_reread_flag got %b want 0", a_coll); else pass_cnt++;
    endtask

    task automatic test_hold();
        a_ce1 = 1; a_a1 = 12'h000;
        tick();
        a_ce1 = 0;
        total_cnt++; if (a_q1 !== 16'hBEEF) $display("FAIL hold_first got %h want BEEF", a_q1); else pass_cnt++;
        a_ce0 = 1; a_we0 = 1; a_a0 = 12'h000; a_d0 = 16'h0000; a_wem0 = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (a_q1 !== 16'hBEEF) $display("FAIL hold_cycle%0d got %h want BEEF", i, a_q1); else pass_cnt++;
        end
        a_ce0 = 0; a_we0 = 0;
    endtask

    task automatic test_outreg_odd();
        b_ce0 = 1; b_we0 = 1; b_a0 = 12'h7FF; b_d0 = 12'hABC; b_wem0 = 12'hFFF;
        tick();
        b_ce0 = 0; b_we0 = 0;
        b_ce1 = 1; b_a1 = 12'h7FF;
        tick();
        b_ce1 = 0;
        total_cnt++; if (b_q1 !== 12'h000) $display("FAIL outreg_lat1 got %h want 000", b_q1); else pass_cnt++;
        tick();
        total_cnt++; if (b_q1 !== 12'hABC) $display("FAIL outreg_lat2 got %h want ABC", b_q1); else pass_cnt++;
        tick();
        total_cnt++; if (b_q1 !== 12'hABC) $display("FAIL outreg_hold got %h want ABC", b_q1); else pass_cnt++;
    endtask

    task automatic test_outreg_collision();
        b_ce0 = 1; b_we0 = 1; b_a0 = 12'h7FF; b_d0 = 12'h123; b_wem0 = 12'h0F0;
        b_ce1 = 1; b_a1 = 12'h7FF;
        tick();
        b_ce0 = 0; b_we0 = 0; b_ce1 = 0;
        total_cnt++; if (b_coll !== 1'b0) $display("FAIL outreg_coll_early got %b want 0", b_coll); else pass_cnt++;
        tick();
        total_cnt++; if (b_q1 !== 12'hA2C) $display("FAIL outreg_coll_data got %h want A2C", b_q1); else pass_cnt++;
        total_cnt++; if (b_coll !== 1'b1) $display("FAIL outreg_coll_flag got %b want 1", b_coll); else pass_cnt++;
        tick();
        total_cnt++; if (b_coll !== 1'b0) $display("FAIL outreg_coll_pulse got %b want 0", b_coll); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        a_ce1 = 1; a_a1 = 12'h005;
        b_ce1 = 1; b_a1 = 12'h7FF;
        tick();
        a_ce1 = 0; b_ce1 = 0;
        total_cnt++; if (a_q1 !== 16'h12F4) $display("FAIL pre_reset_read got %h want 12F4", a_q1); else pass_cnt++;
        RSTN = 0;
        #1;
        total_cnt++; if (a_q1 !== 16'h0) $display("FAIL midreset_a_q1 got %h want 0000", a_q1); else pass_cnt++;
        total_cnt++; if (b_q1 !== 12'h0) $display("FAIL midreset_b_q1 got %h want 000", b_q1); else pass_cnt++;
        total_cnt++; if (b_coll !== 1'b0) $display("FAIL midreset_b_coll got %b want 0", b_coll); else pass_cnt++;
        tick();
        RSTN = 1;
        tick();
        total_cnt++; if (b_q1 !== 12'h0) $display("FAIL post_reset_b_idle got %h want 000", b_q1); else pass_cnt++;
        a_ce1 = 1; a_a1 = 12'h010;
        b_ce1 = 1; b_a1 = 12'h7FF;
        tick();
        a_ce1 = 0; b_ce1 = 0;
        total_cnt++; if (a_q1 !== 16'h55AA) $display("FAIL retained_a got %h want 55AA", a_q1); else pass_cnt++;
        tick();
        total_cnt++; if (b_q1 !== 12'hA2C) $display("FAIL retained_b got %h want A2C", b_q1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_banks();
        test_mask();
        test_collision();
        test_hold();
        test_outreg_odd();
        test_outreg_collision();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
